// File: rtl/riscv_dcache_tag_sa_if.sv
// Purpose: lookup/replace/flush bundle between the cache FSM and the tag/state array.
// Latency: lookup outputs are combinational; state changes commit on the falling clock edge.
// Backpressure: flush writebacks hold wb_valid with stable wb_* until wb_ready is seen high.
interface riscv_dcache_tag_sa_if #(
  parameter int IDX  = 10,
  parameter int TAG  = 11,
  parameter int WAYS = 4
);
  localparam int WB = $clog2(WAYS);

  logic [IDX-1:0] index;
  logic [TAG-1:0] tag_in;
  logic           access;
  logic           mark_dirty;
  logic           replace_tag;
  logic           valid_in;
  logic           dirty_in;
  logic           hit;
  logic [WB-1:0]  hit_way;
  logic [WB-1:0]  victim_way;
  logic           victim_dirty;
  logic [TAG-1:0] victim_tag;
  logic           flush_req;
  logic           flush_busy;
  logic           flush_done;
  logic           wb_valid;
  logic           wb_ready;
  logic [IDX-1:0] wb_index;
  logic [WB-1:0]  wb_way;
  logic [TAG-1:0] wb_tag;

  modport master (
    output index, tag_in, access, mark_dirty, replace_tag, valid_in, dirty_in,
           flush_req, wb_ready,
    input  hit, hit_way, victim_way, victim_dirty, victim_tag,
           flush_busy, flush_done, wb_valid, wb_index, wb_way, wb_tag
  );

  modport slave (
    input  index, tag_in, access, mark_dirty, replace_tag, valid_in, dirty_in,
           flush_req, wb_ready,
    output hit, hit_way, victim_way, victim_dirty, victim_tag,
           flush_busy, flush_done, wb_valid, wb_index, wb_way, wb_tag
  );
endinterface

// File: rtl/riscv_dcache_tag_sa.sv
// Purpose: set-associative tag/valid/dirty array with tree pseudo-LRU and a flush engine.
// Latency: hit/victim lookup is zero-cycle combinational; updates commit on negedge clk.
// Backpressure: flush stalls in WB until wb_ready; lookups are blocked while flushing.
module riscv_dcache_tag_sa #(
  parameter int IDX  = 10,
  parameter int TAG  = 11,
  parameter int WAYS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_dcache_tag_sa_if.slave bus
);
  localparam int SETS = 2 ** IDX;
  localparam int WB   = $clog2(WAYS);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB, S_DONE} state_t;

  // Tree bits live at heap positions 1..WAYS-1; bit 0 is never addressed.
  // A tree bit of 1 steers the victim search toward the upper half.
  logic [TAG-1:0]  r_tag   [SETS][WAYS];
  logic [WAYS-1:0] r_valid [SETS];
  logic [WAYS-1:0] r_dirty [SETS];
  logic [WAYS-1:0] r_plru  [SETS];

  state_t             r_state;
  logic [IDX+WB-1:0]  r_cur;
  logic               r_busy;
  logic               r_done;
  logic               r_wb_vld;

  logic [WAYS-1:0] w_match;
  logic            w_hit;
  logic [WB-1:0]   w_hit_way;
  logic            w_any_inv;
  logic [WB-1:0]   w_inv_way;
  logic [WB-1:0]   w_victim_way;
  logic            w_idle;
  logic            w_rep_we;
  logic            w_touch_hit;
  logic [IDX-1:0]  w_cur_set;
  logic [WB-1:0]   w_cur_way;
  logic            w_cur_last;

  function automatic logic [WB-1:0] plru_victim(input logic [WAYS-1:0] t);
    int n;
    n = 1;
    for (int l = 0; l < WB; l++) n = 2 * n + int'(t[WB'(n)]);
    return WB'(n - WAYS);
  endfunction

  // Point every node on the path to way w at the opposite subtree.
  function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] t, input logic [WB-1:0] w);
    logic [WAYS-1:0] r;
    logic [WB-1:0]   node;
    r = t;
    for (int l = 0; l < WB; l++) begin
      node    = WB'((WAYS + int'(w)) >> (WB - l));
      r[node] = (((int'(w) >> (WB - 1 - l)) & 1) == 0);
    end
    return r;
  endfunction

  assign w_idle      = (r_state == S_IDLE);
  assign w_cur_set   = r_cur[IDX+WB-1:WB];
  assign w_cur_way   = r_cur[WB-1:0];
  assign w_cur_last  = &r_cur;
  assign w_rep_we    = w_idle && bus.replace_tag;
  assign w_touch_hit = w_idle && bus.access && w_hit;

  // Tag compare across ways and lowest-numbered invalid way of the addressed set.
  always_comb begin
    w_match   = '0;
    w_hit_way = '0;
    w_inv_way = '0;
    w_any_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      w_match[w] = r_valid[bus.index][w] && (r_tag[bus.index][w] == bus.tag_in);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_match[w]) w_hit_way = WB'(w);
      if (!r_valid[bus.index][w]) begin
        w_inv_way = WB'(w);
        w_any_inv = 1'b1;
      end
    end
  end

  assign w_hit        = |w_match;
  assign w_victim_way = w_any_inv ? w_inv_way : plru_victim(r_plru[bus.index]);

  assign bus.hit          = w_hit && !r_busy;
  assign bus.hit_way      = (w_hit && !r_busy) ? w_hit_way : '0;
  assign bus.victim_way   = w_victim_way;
  assign bus.victim_dirty = r_valid[bus.index][w_victim_way] && r_dirty[bus.index][w_victim_way];
  assign bus.victim_tag   = r_tag[bus.index][w_victim_way];
  assign bus.flush_busy   = r_busy;
  assign bus.flush_done   = r_done;
  assign bus.wb_valid     = r_wb_vld;
  assign bus.wb_index     = w_cur_set;
  assign bus.wb_way       = w_cur_way;
  assign bus.wb_tag       = r_tag[w_cur_set][w_cur_way];

  // Tag storage has no reset; only the replace path writes it.
  always_ff @(negedge clk) begin
    if (w_rep_we) r_tag[bus.index][w_victim_way] <= bus.tag_in;
  end

  // Valid/dirty/PLRU update and flush engine walking every (set, way) in order.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
      r_state  <= S_IDLE;
      r_cur    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wb_vld <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rep_we) begin
            r_valid[bus.index][w_victim_way] <= bus.valid_in;
            r_dirty[bus.index][w_victim_way] <= bus.dirty_in;
            r_plru[bus.index] <= plru_touch(r_plru[bus.index], w_victim_way);
          end else if (w_touch_hit) begin
            r_plru[bus.index] <= plru_touch(r_plru[bus.index], w_hit_way);
            if (bus.mark_dirty) r_dirty[bus.index][w_hit_way] <= 1'b1;
          end
          if (bus.flush_req) begin
            r_state <= S_SCAN;
            r_cur   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SCAN, S_WB: begin
          if (r_state == S_SCAN && r_valid[w_cur_set][w_cur_way] && r_dirty[w_cur_set][w_cur_way]) begin
            r_state  <= S_WB;
            r_wb_vld <= 1'b1;
          end else if (r_state == S_SCAN || bus.wb_ready) begin
            r_valid[w_cur_set][w_cur_way] <= 1'b0;
            r_dirty[w_cur_set][w_cur_way] <= 1'b0;
            r_wb_vld <= 1'b0;
            if (w_cur_last) begin
              for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cur   <= r_cur + 1'b1;
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
